compute_decoder: RTL and testbench

Inverse stage for the sum-of-operands compute path: accepts a `(FOO+1)`-bit sum and one `FOO`-bit operand, and recovers the other operand as `sum - operand1`. Results are buffered in a small FIFO and presented on a valid/ready stream. Beats whose recovered operand does not fit in `FOO` bits are flagged and counted. It sits downstream of the compute unit and feeds the checker/consumer logic.

---
 rtl/compute_decoder_if.sv | 27 ++
 rtl/compute_decoder.sv | 99 +++++++++
 tb/tb_compute_decoder.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/compute_decoder_if.sv
// Stream bundle for compute_decoder: input beats (sum, known operand),
// recovered-operand output beats and status.
interface compute_decoder_if #(
  parameter int FOO   = 8,
  parameter int DEPTH = 4
);
  logic                     s_valid_i;
  logic                     s_ready_o;
  logic [FOO:0]             s_sum_i;
  logic [FOO-1:0]           s_operand1_i;
  logic                     m_valid_o;
  logic                     m_ready_i;
  logic [FOO-1:0]           m_operand2_o;
  logic                     m_error_o;
  logic [7:0]               err_count_o;
  logic [$clog2(DEPTH):0]   level_o;

  modport master (
    output s_valid_i, s_sum_i, s_operand1_i, m_ready_i,
    input  s_ready_o, m_valid_o, m_operand2_o, m_error_o, err_count_o, level_o
  );

  modport slave (
    input  s_valid_i, s_sum_i, s_operand1_i, m_ready_i,
    output s_ready_o, m_valid_o, m_operand2_o, m_error_o, err_count_o, level_o
  );
endinterface

// File: rtl/compute_decoder.sv
// Recovers operand2 = sum - operand1, flags out-of-range results, and buffers
// them in a small FIFO on a valid/ready stream with a saturating error count.
module compute_decoder #(
  parameter int FOO   = 8,
  parameter int DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  compute_decoder_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  // Bit FOO of the wrapped difference doubles as the out-of-range flag.
  function automatic logic [FOO:0] recover_f(input logic [FOO:0]   sum,
                                             input logic [FOO-1:0] op1);
    return sum - {1'b0, op1};
  endfunction

  logic [FOO:0]    mem_r [DEPTH];
  logic [PW-1:0]   wr_ptr_r;
  logic [PW-1:0]   rd_ptr_r;
  logic [LW-1:0]   level_r;
  logic [7:0]      err_count_r;

  logic            full_s;
  logic            empty_s;
  logic            push_s;
  logic            pop_s;
  logic [FOO:0]    diff_s;
  logic [FOO:0]    head_s;

  // Handshake qualification and operand recovery
  always_comb begin
    full_s  = (level_r == FULL_LEVEL);
    empty_s = (level_r == {LW{1'b0}});
    push_s  = bus.s_valid_i && !full_s;
    pop_s   = !empty_s && bus.m_ready_i;
    diff_s  = recover_f(bus.s_sum_i, bus.s_operand1_i);
  end

  // Head entry, forced to zero while empty so stale storage never shows
  always_comb begin
    if (empty_s) begin
      head_s = {(FOO+1){1'b0}};
    end else begin
      head_s = mem_r[rd_ptr_r];
    end
  end

  // FIFO storage; contents need no reset because the head is masked when empty
  always_ff @(posedge clk_i) begin
    if (push_s && !rst_i) begin
      mem_r[wr_ptr_r] <= diff_s;
    end
  end

  // Pointers and occupancy; reset wins over push and pop on the same edge
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Saturating count of accepted error beats, independent of popping
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_count_r <= 8'd0;
    end else if (push_s && diff_s[FOO] && (err_count_r != 8'hFF)) begin
      err_count_r <= err_count_r + 8'd1;
    end else begin
      err_count_r <= err_count_r;
    end
  end

  assign bus.s_ready_o    = !full_s;
  assign bus.m_valid_o    = !empty_s;
  assign bus.m_operand2_o = head_s[FOO-1:0];
  assign bus.m_error_o    = head_s[FOO];
  assign bus.err_count_o  = err_count_r;
  assign bus.level_o      = level_r;

endmodule

// File: tb/tb_compute_decoder.sv
// Scoreboard bench for compute_decoder: expected beats are queued on accept
// and compared against the head every cycle and on each pop.
module tb_compute_decoder;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   err_exp = 0;
  logic [8:0] q[$];
  bit   acc;

  always #5 clk_i = ~clk_i;

  compute_decoder_if #(.FOO(8), .DEPTH(4)) bus ();

  compute_decoder #(.FOO(8), .DEPTH(4)) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: check state at negedge, advance the model, return #1 after posedge.
  task automatic cycle(output bit accepted);
    bit do_pop;
    bit do_push;
    logic [8:0] d;
    accepted = 1'b0;
    @(negedge clk_i);
    check_eq("level", bus.level_o, q.size());
    check_eq("s_ready", bus.s_ready_o, q.size() != 4);
    check_eq("m_valid", bus.m_valid_o, q.size() != 0);
    check_eq("err_count", bus.err_count_o, err_exp);
    if (q.size() != 0) begin
      check_eq("head_op2", bus.m_operand2_o, q[0][7:0]);
      check_eq("head_err", bus.m_error_o, q[0][8]);
    end else begin
      check_eq("empty_op2", bus.m_operand2_o, 32'd0);
      check_eq("empty_err", bus.m_error_o, 32'd0);
    end
    if (rst_i) begin
      q.delete();
      err_exp = 0;
    end else begin
      do_pop  = (q.size() != 0) && bus.m_ready_i;
      do_push = bus.s_valid_i && (q.size() != 4);
      if (do_pop) void'(q.pop_front());
      if (do_push) begin
        d = bus.s_sum_i - {1'b0, bus.s_operand1_i};
        q.push_back(d);
        if (d[8] && err_exp < 255) err_exp++;
        accepted = 1'b1;
      end
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input bit v, input logic [8:0] sum, input logic [7:0] op1);
    bus.s_valid_i    = v;
    bus.s_sum_i      = sum;
    bus.s_operand1_i = op1;
  endtask

  initial begin
    logic [7:0] op;
    drive(1'b0, 9'd0, 8'd0);
    bus.m_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    cycle(acc);

    // Basic recovery
    bus.m_ready_i = 1'b1;
    drive(1'b1, 9'h123, 8'h45);
    cycle(acc);
    drive(1'b0, 9'd0, 8'd0);
    check_eq("basic_valid", bus.m_valid_o, 32'd1);
    check_eq("basic_op2", bus.m_operand2_o, 32'hDE);
    check_eq("basic_err", bus.m_error_o, 32'd0);
    cycle(acc);

    // Underflow error
    drive(1'b1, 9'h010, 8'h20);
    cycle(acc);
    drive(1'b0, 9'd0, 8'd0);
    check_eq("uflow_op2", bus.m_operand2_o, 32'hF0);
    check_eq("uflow_err", bus.m_error_o, 32'd1);
    check_eq("uflow_cnt", bus.err_count_o, 32'd1);
    cycle(acc);

    // Overflow error
    drive(1'b1, 9'h1FF, 8'h00);
    cycle(acc);
    drive(1'b0, 9'd0, 8'd0);
    check_eq("oflow_op2", bus.m_operand2_o, 32'hFF);
    check_eq("oflow_err", bus.m_error_o, 32'd1);
    check_eq("oflow_cnt", bus.err_count_o, 32'd2);
    cycle(acc);

    // Fill and drain
    bus.m_ready_i = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 9'(i), 8'd0);
      cycle(acc);
    end
    drive(1'b1, 9'd5, 8'd0);
    cycle(acc);
    check_eq("full_level", bus.level_o, 32'd4);
    check_eq("full_ready", bus.s_ready_o, 32'd0);
    check_eq("full_hold_op2", bus.m_operand2_o, 32'd1);
    bus.m_ready_i = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 10 && !acc; k++) cycle(acc);
    check_eq("fill_5th_accept", acc, 32'd1);
    drive(1'b0, 9'd0, 8'd0);
    for (int k = 0; k < 10 && bus.m_valid_o; k++) cycle(acc);
    check_eq("drain_empty", bus.m_valid_o, 32'd0);

    // Simultaneous push and pop at level 2, across pointer wrap
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 9'($urandom_range(511)), 8'($urandom_range(255)));
      cycle(acc);
    end
    bus.m_ready_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 9'($urandom_range(511)), 8'($urandom_range(255)));
      cycle(acc);
      check_eq("stream_level", bus.level_o, 32'd2);
    end
    drive(1'b0, 9'd0, 8'd0);
    for (int k = 0; k < 10 && bus.m_valid_o; k++) cycle(acc);

    // Saturation with back-to-back error beats
    for (int i = 0; i < 300; i++) begin
      op = 8'($urandom_range(255, 1));
      drive(1'b1, 9'($urandom_range(int'(op) - 1, 0)), op);
      cycle(acc);
      check_eq("sat_level", bus.level_o <= 3'd1, 32'd1);
    end
    drive(1'b0, 9'd0, 8'd0);
    cycle(acc);
    check_eq("sat_cnt", bus.err_count_o, 32'd255);
    for (int k = 0; k < 10 && bus.m_valid_o; k++) cycle(acc);

    // Reset mid-operation with a beat presented during reset
    bus.m_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 9'($urandom_range(511)), 8'($urandom_range(255)));
      cycle(acc);
    end
    check_eq("pre_rst_level", bus.level_o, 32'd3);
    rst_i = 1'b1;
    drive(1'b1, 9'h0AA, 8'h55);
    cycle(acc);
    rst_i = 1'b0;
    drive(1'b0, 9'd0, 8'd0);
    check_eq("rst_level", bus.level_o, 32'd0);
    check_eq("rst_valid", bus.m_valid_o, 32'd0);
    check_eq("rst_cnt", bus.err_count_o, 32'd0);
    check_eq("rst_ready", bus.s_ready_o, 32'd1);
    check_eq("rst_op2", bus.m_operand2_o, 32'd0);
    repeat (2) cycle(acc);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
